// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI3 responder over a word-addressed on-chip SRAM model.
// Optional macro AXI_SRAM_SLAVE_ERR_RESP_EN enables DECERR/SLVERR responses.
module axi_sram_slave #(
  parameter int MEM_WORDS_LOG2 = 12,
  parameter bit INIT_ZERO      = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  ARID,
  input  logic [31:0] ARADDR,
  input  logic [7:0]  ARLEN,
  input  logic [2:0]  ARSIZE,
  input  logic [1:0]  ARBURST,
  input  logic [1:0]  ARLOCK,
  input  logic [3:0]  ARCACHE,
  input  logic [2:0]  ARPROT,
  input  logic        ARVALID,
  output logic        ARREADY,
  output logic [3:0]  RID,
  output logic [31:0] RDATA,
  output logic [1:0]  RRESP,
  output logic        RLAST,
  output logic        RVALID,
  input  logic        RREADY,
  input  logic [3:0]  AWID,
  input  logic [31:0] AWADDR,
  input  logic [7:0]  AWLEN,
  input  logic [2:0]  AWSIZE,
  input  logic [1:0]  AWBURST,
  input  logic [1:0]  AWLOCK,
  input  logic [3:0]  AWCACHE,
  input  logic [2:0]  AWPROT,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [3:0]  WID,
  input  logic [31:0] WDATA,
  input  logic [3:0]  WSTRB,
  input  logic        WLAST,
  input  logic        WVALID,
  output logic        WREADY,
  output logic [3:0]  BID,
  output logic [1:0]  BRESP,
  output logic        BVALID,
  input  logic        BREADY
);
  localparam int AW    = MEM_WORDS_LOG2;
  localparam int DEPTH = 1 << AW;

  typedef enum logic {R_IDLE, R_DATA} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

  // Never touched by reset; the initializer only models power-up contents.
  logic [31:0] r_mem [DEPTH] = '{default: (INIT_ZERO ? 32'h0 : 32'hx)};

  function automatic logic [1:0] eff_size(input logic [2:0] s);
    return (s > 3'd2) ? 2'd2 : s[1:0];
  endfunction

`ifdef AXI_SRAM_SLAVE_ERR_RESP_EN
  function automatic logic [1:0] beat_resp(input logic [31:0] a,
                                           input logic [1:0]  s);
    if (|a[31:AW+2]) return 2'b11;
    if ((s == 2'd1 && a[0]) || (s == 2'd2 && |a[1:0])) return 2'b10;
    return 2'b00;
  endfunction
`endif

  rstate_t     r_rstate;
  logic        r_arready, r_rvalid, r_rlast, r_rfixed;
  logic [3:0]  r_rid;
  logic [31:0] r_rdata, r_raddr;
  logic [1:0]  r_rresp, r_rsize;
  logic [7:0]  r_rlen, r_rcnt;

  logic          w_ar_fire, w_r_fire, w_rld;
  logic [31:0]   w_raddr_nx, w_rld_addr;
  logic [1:0]    w_rld_size, w_rld_resp;
  logic [AW-1:0] w_rld_idx;

  assign w_ar_fire  = (r_rstate == R_IDLE) && ARVALID && r_arready;
  assign w_r_fire   = (r_rstate == R_DATA) && RREADY && r_rvalid;
  assign w_rld      = w_ar_fire || (w_r_fire && !r_rlast);
  assign w_raddr_nx = r_rfixed ? r_raddr : r_raddr + (32'd1 << r_rsize);
  assign w_rld_addr = w_ar_fire ? ARADDR : w_raddr_nx;
  assign w_rld_size = w_ar_fire ? eff_size(ARSIZE) : r_rsize;
  assign w_rld_idx  = w_rld_addr[AW+1:2];
`ifdef AXI_SRAM_SLAVE_ERR_RESP_EN
  assign w_rld_resp = beat_resp(w_rld_addr, w_rld_size);
`else
  assign w_rld_resp = 2'b00;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rfixed  <= 1'b0;
      r_rid     <= '0;
      r_rdata   <= '0;
      r_rresp   <= '0;
      r_raddr   <= '0;
      r_rsize   <= '0;
      r_rlen    <= '0;
      r_rcnt    <= '0;
    end else begin
      unique case (r_rstate)
        R_IDLE: begin
          if (w_ar_fire) begin
            r_rstate  <= R_DATA;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rid     <= ARID;
            r_raddr   <= ARADDR;
            r_rsize   <= eff_size(ARSIZE);
            r_rlen    <= ARLEN;
            r_rfixed  <= (ARBURST == 2'b00);
            r_rcnt    <= '0;
            r_rlast   <= (ARLEN == 8'd0);
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (w_r_fire) begin
            if (r_rlast) begin
              r_rstate  <= R_IDLE;
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_arready <= 1'b1;
            end else begin
              r_raddr <= w_raddr_nx;
              r_rcnt  <= r_rcnt + 8'd1;
              r_rlast <= (r_rcnt + 8'd1 == r_rlen);
            end
          end
        end
      endcase
      // Array is read here and written in the block below: old data wins.
      if (w_rld) begin
        r_rdata <= (w_rld_resp == 2'b11) ? '0 : r_mem[w_rld_idx];
        r_rresp <= w_rld_resp;
      end
    end
  end

  wstate_t     r_wstate;
  logic        r_awready, r_wready, r_bvalid, r_wfixed;
  logic [3:0]  r_bid;
  logic [31:0] r_waddr;
  logic [1:0]  r_wsize, r_wacc, r_bresp;
  logic [7:0]  r_wlen, r_wcnt;

  logic          w_aw_fire, w_w_fire, w_b_fire, w_wen;
  logic [31:0]   w_waddr_nx;
  logic [1:0]    w_wresp, w_wacc_nx;
  logic [AW-1:0] w_widx;

  assign w_aw_fire  = (r_wstate == W_IDLE) && AWVALID && r_awready;
  assign w_w_fire   = (r_wstate == W_DATA) && WVALID && r_wready;
  assign w_b_fire   = (r_wstate == W_RESP) && BREADY && r_bvalid;
  assign w_waddr_nx = r_wfixed ? r_waddr : r_waddr + (32'd1 << r_wsize);
  assign w_widx     = r_waddr[AW+1:2];
`ifdef AXI_SRAM_SLAVE_ERR_RESP_EN
  assign w_wresp = beat_resp(r_waddr, r_wsize);
`else
  assign w_wresp = 2'b00;
`endif
  assign w_wen = w_w_fire && !reset && (w_wresp != 2'b11);

  always_comb begin
    w_wacc_nx = r_wacc;
    if (w_wresp == 2'b11 || r_wacc == 2'b11) w_wacc_nx = 2'b11;
    else if (w_wresp == 2'b10) w_wacc_nx = 2'b10;
  end

  always_ff @(posedge clk) begin
    if (w_wen) begin
      for (int i = 0; i < 4; i++) begin
        if (WSTRB[i]) r_mem[w_widx][8*i +: 8] <= WDATA[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_wfixed  <= 1'b0;
      r_bid     <= '0;
      r_bresp   <= '0;
      r_waddr   <= '0;
      r_wsize   <= '0;
      r_wacc    <= '0;
      r_wlen    <= '0;
      r_wcnt    <= '0;
    end else begin
      unique case (r_wstate)
        W_IDLE: begin
          if (w_aw_fire) begin
            r_wstate  <= W_DATA;
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_bid     <= AWID;
            r_waddr   <= AWADDR;
            r_wsize   <= eff_size(AWSIZE);
            r_wlen    <= AWLEN;
            r_wfixed  <= (AWBURST == 2'b00);
            r_wcnt    <= '0;
            r_wacc    <= '0;
          end else begin
            r_awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_w_fire) begin
            r_waddr <= w_waddr_nx;
            r_wcnt  <= r_wcnt + 8'd1;
            r_wacc  <= w_wacc_nx;
            // Beat count, not WLAST, ends the burst.
            if (r_wcnt == r_wlen) begin
              r_wstate <= W_RESP;
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= w_wacc_nx;
            end
          end
        end
        W_RESP: begin
          if (w_b_fire) begin
            r_wstate  <= W_IDLE;
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  assign ARREADY = r_arready;
  assign RID     = r_rid;
  assign RDATA   = r_rdata;
  assign RRESP   = r_rresp;
  assign RLAST   = r_rlast;
  assign RVALID  = r_rvalid;
  assign AWREADY = r_awready;
  assign WREADY  = r_wready;
  assign BID     = r_bid;
  assign BRESP   = r_bresp;
  assign BVALID  = r_bvalid;

  logic w_unused;
`ifdef AXI_SRAM_SLAVE_ERR_RESP_EN
  assign w_unused = ^{ARLOCK, ARCACHE, ARPROT, AWLOCK, AWCACHE, AWPROT,
                      WID, WLAST};
`else
  assign w_unused = ^{ARLOCK, ARCACHE, ARPROT, AWLOCK, AWCACHE, AWPROT,
                      WID, WLAST, w_rld_size, w_rld_addr, r_waddr};
`endif

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed checks of axi_sram_slave transfers,
// strobes, bursts, backpressure, collision and mid-burst reset.
module tb_axi_sram_slave;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  ARID = '0;
  logic [31:0] ARADDR = '0;
  logic [7:0]  ARLEN = '0;
  logic [2:0]  ARSIZE = 3'd2;
  logic [1:0]  ARBURST = 2'd1;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [3:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST, RVALID;
  logic        RREADY = 1'b0;
  logic [3:0]  AWID = '0;
  logic [31:0] AWADDR = '0;
  logic [7:0]  AWLEN = '0;
  logic [2:0]  AWSIZE = 3'd2;
  logic [1:0]  AWBURST = 2'd1;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        WLAST = 1'b0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  axi_sram_slave dut (
    .clk(clk), .reset(reset),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARLOCK(2'b00), .ARCACHE(4'h0), .ARPROT(3'b000),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWLOCK(2'b00), .AWCACHE(4'h0), .AWPROT(3'b000),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(4'h0), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic aw(input logic [3:0] id, input logic [31:0] a,
                    input logic [7:0] len, input logic [1:0] burst);
    int n;
    n = 0;
    AWID = id; AWADDR = a; AWLEN = len; AWSIZE = 3'd2;
    AWBURST = burst; AWVALID = 1'b1;
    while (!AWREADY && n < 20) begin tick(); n++; end
    chk("aw_wait", 32'(n < 20), 1);
    tick();
    AWVALID = 1'b0;
  endtask

  task automatic wbeat(input logic [31:0] d, input logic [3:0] s,
                       input logic l);
    int n;
    n = 0;
    WDATA = d; WSTRB = s; WLAST = l; WVALID = 1'b1;
    while (!WREADY && n < 20) begin tick(); n++; end
    chk("w_wait", 32'(n < 20), 1);
    tick();
    WVALID = 1'b0; WLAST = 1'b0;
  endtask

  task automatic bresp(input logic [3:0] id, input logic late);
    int n;
    n = 0;
    while (!BVALID && n < 20) begin tick(); n++; end
    chk("b_wait", 32'(n < 20), 1);
    chk("b_id", BID, id);
    chk("b_resp", BRESP, 2'b00);
    chk("b_wready_low", WREADY, 0);
    if (late) begin
      tick();
      chk("b_hold", BVALID, 1);
    end
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    chk("b_done_valid", BVALID, 0);
    chk("b_done_awready", AWREADY, 1);
  endtask

  task automatic ar(input logic [3:0] id, input logic [31:0] a,
                    input logic [7:0] len, input logic [1:0] burst);
    int n;
    n = 0;
    ARID = id; ARADDR = a; ARLEN = len; ARSIZE = 3'd2;
    ARBURST = burst; ARVALID = 1'b1;
    while (!ARREADY && n < 20) begin tick(); n++; end
    chk("ar_wait", 32'(n < 20), 1);
    tick();
    ARVALID = 1'b0;
  endtask

  task automatic rbeat(input string tag, input logic [31:0] d,
                       input logic [3:0] id, input logic last,
                       input logic late);
    int n;
    n = 0;
    while (!RVALID && n < 20) begin tick(); n++; end
    chk({tag, "_wait"}, 32'(n < 20), 1);
    chk({tag, "_data"}, RDATA, d);
    chk({tag, "_id"}, RID, id);
    chk({tag, "_last"}, RLAST, last);
    chk({tag, "_resp"}, RRESP, 2'b00);
    if (late) begin
      tick();
      chk({tag, "_hold"}, RVALID, 1);
    end
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    if (last) begin
      chk({tag, "_end_valid"}, RVALID, 0);
      chk({tag, "_end_rlast"}, RLAST, 0);
      chk({tag, "_end_arready"}, ARREADY, 1);
    end
  endtask

  initial begin
    // reset state
    repeat (3) tick();
    chk("rst_arready", ARREADY, 0);
    chk("rst_awready", AWREADY, 0);
    chk("rst_rvalid", RVALID, 0);
    chk("rst_rlast", RLAST, 0);
    chk("rst_wready", WREADY, 0);
    chk("rst_bvalid", BVALID, 0);
    reset = 1'b0;
    tick();
    chk("post_rst_arready", ARREADY, 1);
    chk("post_rst_awready", AWREADY, 1);

    // single write then read
    aw(4'd1, 32'h10, 8'd0, 2'd1);
    chk("aw_then_wready", WREADY, 1);
    chk("aw_then_awready", AWREADY, 0);
    wbeat(32'hDEADBEEF, 4'hF, 1'b1);
    bresp(4'd1, 1'b0);
    ar(4'd1, 32'h10, 8'd0, 2'd1);
    chk("ar_then_rvalid", RVALID, 1);
    chk("ar_then_arready", ARREADY, 0);
    rbeat("single", 32'hDEADBEEF, 4'd1, 1'b1, 1'b0);

    // byte strobes
    aw(4'd2, 32'h20, 8'd0, 2'd1);
    wbeat(32'h11223344, 4'hF, 1'b1);
    bresp(4'd2, 1'b0);
    aw(4'd2, 32'h20, 8'd0, 2'd1);
    wbeat(32'h0000AA00, 4'b0010, 1'b1);
    bresp(4'd2, 1'b0);
    ar(4'd2, 32'h20, 8'd0, 2'd1);
    rbeat("strb", 32'h1122AA44, 4'd2, 1'b1, 1'b0);

    // INCR write/read and FIXED read
    aw(4'd3, 32'h40, 8'd3, 2'd1);
    wbeat(32'd0, 4'hF, 1'b0);
    wbeat(32'd1, 4'hF, 1'b0);
    wbeat(32'd2, 4'hF, 1'b0);
    wbeat(32'd3, 4'hF, 1'b1);
    bresp(4'd3, 1'b0);
    ar(4'd4, 32'h40, 8'd3, 2'd1);
    rbeat("incr0", 32'd0, 4'd4, 1'b0, 1'b0);
    rbeat("incr1", 32'd1, 4'd4, 1'b0, 1'b0);
    rbeat("incr2", 32'd2, 4'd4, 1'b0, 1'b0);
    rbeat("incr3", 32'd3, 4'd4, 1'b1, 1'b0);
    ar(4'd5, 32'h40, 8'd3, 2'd0);
    rbeat("fix0", 32'd0, 4'd5, 1'b0, 1'b0);
    rbeat("fix1", 32'd0, 4'd5, 1'b0, 1'b0);
    rbeat("fix2", 32'd0, 4'd5, 1'b0, 1'b0);
    rbeat("fix3", 32'd0, 4'd5, 1'b1, 1'b0);

    // R backpressure, then late RREADY
    ar(4'd6, 32'h10, 8'd0, 2'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_rvalid", RVALID, 1);
      chk("bp_rdata", RDATA, 32'hDEADBEEF);
      chk("bp_rid", RID, 4'd6);
      tick();
    end
    rbeat("bp", 32'hDEADBEEF, 4'd6, 1'b1, 1'b1);

    // late BREADY
    aw(4'd7, 32'h30, 8'd0, 2'd1);
    wbeat(32'hCAFEF00D, 4'hF, 1'b1);
    bresp(4'd7, 1'b1);

    // stray RREADY/BREADY while idle
    RREADY = 1'b1; BREADY = 1'b1;
    tick(); tick();
    RREADY = 1'b0; BREADY = 1'b0;
    chk("stray_rvalid", RVALID, 0);
    chk("stray_bvalid", BVALID, 0);
    chk("stray_arready", ARREADY, 1);

    // read/write collision
    aw(4'd8, 32'h80, 8'd0, 2'd1);
    wbeat(32'h80808080, 4'hF, 1'b1);
    bresp(4'd8, 1'b0);
    aw(4'd8, 32'h84, 8'd0, 2'd1);
    wbeat(32'h84848484, 4'hF, 1'b1);
    bresp(4'd8, 1'b0);
    aw(4'd9, 32'h84, 8'd0, 2'd1);
    ar(4'd10, 32'h80, 8'd1, 2'd1);
    chk("coll_b1_data", RDATA, 32'h80808080);
    chk("coll_b1_last", RLAST, 0);
    RREADY = 1'b1;
    WDATA = 32'h55; WSTRB = 4'hF; WLAST = 1'b1; WVALID = 1'b1;
    tick();
    RREADY = 1'b0; WVALID = 1'b0; WLAST = 1'b0;
    chk("coll_bvalid", BVALID, 1);
    rbeat("coll_b2", 32'h84848484, 4'd10, 1'b1, 1'b0);
    bresp(4'd9, 1'b0);
    ar(4'd11, 32'h84, 8'd0, 2'd1);
    rbeat("coll_new", 32'h55, 4'd11, 1'b1, 1'b0);

    // reset in the middle of a burst
    ar(4'd12, 32'h40, 8'd7, 2'd1);
    rbeat("mid_b1", 32'd0, 4'd12, 1'b0, 1'b0);
    chk("mid_b2_valid", RVALID, 1);
    chk("mid_b2_data", RDATA, 32'd1);
    reset = 1'b1;
    tick();
    chk("mid_rst_rvalid", RVALID, 0);
    chk("mid_rst_rlast", RLAST, 0);
    chk("mid_rst_arready", ARREADY, 0);
    reset = 1'b0;
    tick();
    chk("mid_rel_arready", ARREADY, 1);
    ar(4'd13, 32'h10, 8'd0, 2'd1);
    rbeat("fresh", 32'hDEADBEEF, 4'd13, 1'b1, 1'b0);

`ifdef AXI_SRAM_SLAVE_ERR_RESP_EN
    ar(4'd14, 32'h80000000, 8'd0, 2'd1);
    chk("err_rvalid", RVALID, 1);
    chk("err_rresp", RRESP, 2'b11);
    chk("err_rdata", RDATA, 32'h0);
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI3 responder (slave) fronting an on-chip word-addressed SRAM model; the far end of the CPU's data/instruction RAM AXI masters.
- Used in simulation and FPGA builds as the memory target for the mycpu interfaces.
- Independent read and write channels, each with its own FSM; both may be active concurrently.
- Supports FIXED and INCR bursts up to 256 beats, narrow sizes and WSTRB byte enables.

Parameters:
- MEM_WORDS_LOG2, 12, log2 of SRAM depth in 32-bit words (default 16 KiB).
- INIT_ZERO, 1, 1 = array cleared at time zero in simulation; 0 = left X. The array is never reset by `reset`.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- ARID  in  4  read id
- ARADDR  in  32  read byte address
- ARLEN  in  8  beats-1
- ARSIZE  in  3  bytes per beat = 1<<ARSIZE
- ARBURST  in  2  0 FIXED, 1 INCR, 2 WRAP (treated as INCR)
- ARLOCK/ARCACHE/ARPROT  in  2/4/3  accepted, ignored
- ARVALID  in  1  address valid
- ARREADY  out  1  address accept
- RID  out  4  read id echo
- RDATA  out  32  read data, full word
- RRESP  out  2  read response
- RLAST  out  1  last beat
- RVALID  out  1  data valid
- RREADY  in  1  master accept
- AWID, AWADDR, AWLEN, AWSIZE, AWBURST  in  4/32/8/3/2  as AR equivalents
- AWLOCK/AWCACHE/AWPROT  in  2/4/3  ignored
- AWVALID  in  1;  AWREADY  out  1
- WID  in  4  ignored (not checked against AWID)
- WDATA  in  32;  WSTRB  in  4  byte enables
- WLAST  in  1  ignored for termination
- WVALID  in  1;  WREADY  out  1
- BID  out  4;  BRESP  out  2;  BVALID  out  1;  BREADY  in  1

Behaviour:
- Reset:
  - All outputs 0; both FSMs IDLE.
  - ARREADY/AWREADY rise the first cycle after reset deasserts.
  - Reset mid-burst aborts the burst immediately: no further beats, no B response.
- Addressing:
  - Word index = addr[MEM_WORDS_LOG2+1:2].
  - Effective size = min(SIZE, 2).
  - Beat address step: INCR +(1<<size) using a 32-bit add with wrap at 2^32; FIXED +0.
- Read FSM, R_IDLE -> R_DATA:
  - R_IDLE: ARREADY=1.
  - AR handshake in cycle N latches id, addr, len, size and burst, and registers RDATA=mem[word(ARADDR)].
  - Cycle N+1: ARREADY=0, RVALID=1, RID=latched id, RRESP=OKAY(00).
  - RLAST=1 iff beat counter == latched len.
  - RVALID, RDATA, RID and RLAST hold stable until RREADY=1.
  - Each non-last R handshake advances the address and reloads RDATA on the same edge.
  - Last handshake: next cycle RVALID=0, RLAST=0, ARREADY=1 (R_IDLE).
  - Minimum gap between back-to-back single-beat reads is 2 cycles.
- Write FSM, W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: AWREADY=1, WREADY=0.
  - AW handshake latches id, addr, len, size and burst; next cycle AWREADY=0, WREADY=1.
  - Each W handshake writes mem[word(addr)] byte lanes where WSTRB[i]=1, then advances the address.
  - When the beat counter == latched len on a handshake: next cycle WREADY=0, BVALID=1, BID=latched AWID, BRESP=OKAY.
  - BVALID holds until BREADY. On the B handshake, next cycle BVALID=0, AWREADY=1.
  - WLAST disagreeing with the beat counter is tolerated; termination follows the count.
- Read/write collision:
  - A write to the same word on the same edge that RDATA is loaded returns old data (read-before-write).
  - The next beat sees new data.
- RREADY or BREADY asserted while the matching VALID is 0 has no effect.
- The master's late RREADY/BREADY (one cycle after VALID) must be supported.

Optional Feature:
- Macro AXI_SRAM_SLAVE_ERR_RESP_EN.
- Defined:
  - Address bits [31:MEM_WORDS_LOG2+2] are evaluated per beat.
  - Any nonzero bit gives that R beat RRESP=DECERR(11) and RDATA=0.
  - For writes, any out-of-range beat suppresses its write and gives BRESP=DECERR for the whole burst.
  - An unaligned beat address for its size also gives SLVERR(10); the data is still transferred.
- Undefined:
  - Upper bits are ignored, so addresses alias modulo the SRAM size.
  - RRESP/BRESP are always OKAY.

Test Plan:
- Single write then read:
  - AW addr 0x10, id 1, len 0, size 2; W 0xDEADBEEF, strb 1111 -> BVALID with BID=1, BRESP=00.
  - AR 0x10, id 1 -> RVALID the cycle after ARREADY handshake, RDATA=0xDEADBEEF, RLAST=1, RID=1.
- Byte strobes: write 0x11223344 to 0x20, then WSTRB 0010 data 0x0000AA00 -> read returns 0x1122AA44.
- INCR burst:
  - Write len 3 to 0x40 with 0,1,2,3; read len 3 from 0x40 -> 4 beats 0..3, RLAST on beat 4 only.
  - FIXED read len 3 -> 4 beats all equal mem[0x40].
- Backpressure:
  - Hold RREADY=0 for 5 cycles -> RDATA/RVALID/RID stable.
  - RREADY asserted one cycle after RVALID, as the CPU interface does -> single beat completes, ARREADY=1 the next cycle.
  - Same for BREADY.
- Concurrency and collision:
  - Read len 1 from 0x80 while writing 0x55 to 0x84 with the W handshake on the edge where beat 2 loads -> beat 2 = old value; a subsequent read returns 0x55.
- Reset mid-burst: assert reset during beat 2 of a len 7 read -> next cycle RVALID=0.
  - One cycle after release ARREADY=1; a fresh read succeeds.
  - With AXI_SRAM_SLAVE_ERR_RESP_EN: read 0x80000000 -> RRESP=11, RDATA=0.
